fixp_mac_pipe: RTL and testbench

- Parametrised, pipelined signed fixed-point arithmetic unit for the FPGA CNN datapath. Successor to the plain add/multiply pair.
- Per-beat operation select: ADD, MUL, MAC, MAC_LAST.
- Rescales products back to the Q format with rounding and saturation.
- Holds an internal accumulator for convolution dot-products, with valid/ready handshake and backpressure.

---
 rtl/fixp_pkg.sv | 15 +
 rtl/fixp_sat.sv | 29 ++
 rtl/fixp_mac_pipe.sv | 179 +++++++++++++++++
 tb/tb_fixp_mac_pipe.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixp_pkg.sv
// Shared op codes and default Q-format constants for the fixed-point MAC datapath.
package fixp_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_ADD      = 2'd0;
  localparam op_t OP_MUL      = 2'd1;
  localparam op_t OP_MAC      = 2'd2;
  localparam op_t OP_MAC_LAST = 2'd3;

  localparam int DEFAULT_WIDTH     = 32;
  localparam int DEFAULT_POINT     = 16;
  localparam int DEFAULT_ACC_WIDTH = 48;

endpackage

// File: rtl/fixp_sat.sv
// Signed two's-complement saturator from IN_W down to OUT_W bits, flagging any clamp.
module fixp_sat
  import fixp_pkg::*;
#(
  parameter int IN_W  = DEFAULT_WIDTH + 1,
  parameter int OUT_W = DEFAULT_WIDTH
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout,
  output logic             ovf
);

  localparam int TOP_W = IN_W - OUT_W + 1;

  // The value fits when every bit from the output sign bit upward is a copy of the sign.
  logic [TOP_W-1:0] top;
  assign top = din[IN_W-1:OUT_W-1];
  assign ovf = !((&top) || !(|top));

  always_comb begin
    if (!ovf)
      dout = din[OUT_W-1:0];
    else if (din[IN_W-1])
      dout = {1'b1, {(OUT_W-1){1'b0}}};
    else
      dout = {1'b0, {(OUT_W-1){1'b1}}};
  end

endmodule

// File: rtl/fixp_mac_pipe.sv
// Pipelined signed fixed-point ADD/MUL/MAC unit with rounding, saturation and a dot-product
// accumulator; the whole pipe freezes while the output register is stalled.
module fixp_mac_pipe
  import fixp_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int POINT_WIDTH = DEFAULT_POINT,
  parameter int ACC_WIDTH   = DEFAULT_ACC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sat
);

  localparam int PW    = 2 * WIDTH;
  localparam int RW    = PW + 1 - POINT_WIDTH;
  localparam int SUM_W = ((ACC_WIDTH > RW) ? ACC_WIDTH : RW) + 1;
  localparam logic [PW:0] HALF = {{PW{1'b0}}, 1'b1} << (POINT_WIDTH - 1);

  logic advance;

  logic             s1_valid_reg;
  op_t              s1_op_reg;
  logic [WIDTH-1:0] s1_a_reg;
  logic [WIDTH-1:0] s1_b_reg;

  logic             s2_valid_reg;
  op_t              s2_op_reg;
  logic [PW-1:0]    s2_val_reg;
  logic             s2_flag_reg;

  logic             s3_valid_reg;
  op_t              s3_op_reg;
  logic [RW-1:0]    s3_val_reg;
  logic             s3_flag_reg;

  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic             out_sat_reg;
  logic [ACC_WIDTH-1:0] acc_reg;
  logic             acc_sat_reg;

  logic [WIDTH:0]     add_full;
  logic [WIDTH-1:0]   add_q;
  logic               add_ovf;
  logic [PW-1:0]      a_ext;
  logic [PW-1:0]      b_ext;
  logic [PW-1:0]      prod;
  logic [PW:0]        rnd;
  logic [RW-1:0]      r;
  logic [WIDTH-1:0]   mul_q;
  logic               mul_ovf;
  logic [SUM_W-1:0]   acc_sum;
  logic [ACC_WIDTH-1:0] acc_q;
  logic               acc_ovf;
  logic [WIDTH-1:0]   fin_q;
  logic               fin_ovf;

  assign advance   = !(out_valid_reg && !out_ready);
  assign in_ready  = advance;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sat   = out_sat_reg;

  // Stage 2 arithmetic: WIDTH+1 sum and full-width product from sign-extended operands.
  assign add_full = {s1_a_reg[WIDTH-1], s1_a_reg} + {s1_b_reg[WIDTH-1], s1_b_reg};
  assign a_ext    = {{WIDTH{s1_a_reg[WIDTH-1]}}, s1_a_reg};
  assign b_ext    = {{WIDTH{s1_b_reg[WIDTH-1]}}, s1_b_reg};
  assign prod     = a_ext * b_ext;

  fixp_sat #(.IN_W(WIDTH + 1), .OUT_W(WIDTH)) u_sat_add (
    .din (add_full),
    .dout(add_q),
    .ovf (add_ovf)
  );

  // Round half toward +inf: add half an LSB, then keep the bits above the binary point.
  assign rnd = {s2_val_reg[PW-1], s2_val_reg} + HALF;
  assign r   = rnd[PW:POINT_WIDTH];

  fixp_sat #(.IN_W(RW), .OUT_W(WIDTH)) u_sat_mul (
    .din (s3_val_reg),
    .dout(mul_q),
    .ovf (mul_ovf)
  );

  assign acc_sum = {{(SUM_W - ACC_WIDTH){acc_reg[ACC_WIDTH-1]}}, acc_reg}
                 + {{(SUM_W - RW){s3_val_reg[RW-1]}}, s3_val_reg};

  fixp_sat #(.IN_W(SUM_W), .OUT_W(ACC_WIDTH)) u_sat_acc (
    .din (acc_sum),
    .dout(acc_q),
    .ovf (acc_ovf)
  );

  fixp_sat #(.IN_W(ACC_WIDTH), .OUT_W(WIDTH)) u_sat_fin (
    .din (acc_q),
    .dout(fin_q),
    .ovf (fin_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg  <= 1'b0;
      s1_op_reg     <= OP_ADD;
      s1_a_reg      <= '0;
      s1_b_reg      <= '0;
      s2_valid_reg  <= 1'b0;
      s2_op_reg     <= OP_ADD;
      s2_val_reg    <= '0;
      s2_flag_reg   <= 1'b0;
      s3_valid_reg  <= 1'b0;
      s3_op_reg     <= OP_ADD;
      s3_val_reg    <= '0;
      s3_flag_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sat_reg   <= 1'b0;
      acc_reg       <= '0;
      acc_sat_reg   <= 1'b0;
    end else if (advance) begin
      // Payload registers load only with a valid beat so idle-bus garbage never reaches acc.
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_op_reg <= in_op;
        s1_a_reg  <= in_a;
        s1_b_reg  <= in_b;
      end

      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_op_reg   <= s1_op_reg;
        s2_val_reg  <= (s1_op_reg == OP_ADD) ? {{WIDTH{add_q[WIDTH-1]}}, add_q} : prod;
        s2_flag_reg <= add_ovf;
      end

      s3_valid_reg <= s2_valid_reg;
      if (s2_valid_reg) begin
        s3_op_reg   <= s2_op_reg;
        s3_val_reg  <= (s2_op_reg == OP_ADD)
                       ? {{(RW - WIDTH){s2_val_reg[WIDTH-1]}}, s2_val_reg[WIDTH-1:0]} : r;
        s3_flag_reg <= s2_flag_reg;
      end

      out_valid_reg <= s3_valid_reg && (s3_op_reg != OP_MAC);
      if (s3_valid_reg) begin
        case (s3_op_reg)
          OP_ADD: begin
            out_data_reg <= s3_val_reg[WIDTH-1:0];
            out_sat_reg  <= s3_flag_reg;
          end
          OP_MUL: begin
            out_data_reg <= mul_q;
            out_sat_reg  <= mul_ovf;
          end
          OP_MAC: begin
            acc_reg     <= acc_q;
            acc_sat_reg <= acc_sat_reg | acc_ovf;
          end
          OP_MAC_LAST: begin
            out_data_reg <= fin_q;
            out_sat_reg  <= acc_sat_reg | acc_ovf | fin_ovf;
            acc_reg      <= '0;
            acc_sat_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fixp_mac_pipe.sv
// Scoreboard bench for fixp_mac_pipe: driver feeds a plain-arithmetic reference model, a
// monitor pops expectations whenever a result is transferred.
`timescale 1ns/1ps
module tb_fixp_mac_pipe;
  import fixp_pkg::*;

  localparam int W  = 32;
  localparam int F  = 16;
  localparam int AW = 48;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   in_op = 2'd0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         out_sat;

  typedef struct {
    logic [W-1:0] data;
    logic         sat;
    bit           lat;
    int           acc_cyc;
  } exp_t;

  exp_t         expq[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           beats_out = 0;
  longint       m_acc = 0;
  bit           m_acc_sat = 1'b0;
  bit           bp_en = 1'b0;
  bit           holding = 1'b0;
  logic [W-1:0] hold_data = '0;
  logic         hold_sat = 1'b0;
  int           first_cyc = 0;
  logic [W-1:0] corners [8] = '{32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'h00000001,
                                32'hFFFFFFFF, 32'h00008000, 32'h00010000, 32'hFFFF8000};

  fixp_mac_pipe #(.WIDTH(W), .POINT_WIDTH(F), .ACC_WIDTH(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference arithmetic: real-valued rules evaluated on 64-bit integers.
  function automatic longint clampv(input longint v, input int w, output bit ovf);
    longint hi, lo;
    hi  = (longint'(1) <<< (w - 1)) - 1;
    lo  = -hi - 1;
    ovf = (v > hi) || (v < lo);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic longint scaled_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return (p + (longint'(1) <<< (F - 1))) >>> F;
  endfunction

  task automatic model_beat(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input bit lat, input bit use_exp, input logic [W-1:0] xd,
                            input logic xs);
    exp_t   e;
    longint v;
    longint r;
    bit     o;
    v = 0;
    o = 1'b0;
    r = scaled_prod(a, b);
    e.lat = lat;
    e.acc_cyc = cyc + 1;
    case (op)
      OP_ADD: v = clampv(longint'($signed(a)) + longint'($signed(b)), W, o);
      OP_MUL: v = clampv(r, W, o);
      OP_MAC: begin
        m_acc = clampv(m_acc + r, AW, o);
        m_acc_sat = m_acc_sat | o;
      end
      default: begin
        v = clampv(m_acc + r, W, o);
        o = o | m_acc_sat;
        m_acc = 0;
        m_acc_sat = 1'b0;
      end
    endcase
    if (op != OP_MAC) begin
      e.data = use_exp ? xd : v[W-1:0];
      e.sat  = use_exp ? xs : o;
      expq.push_back(e);
    end
  endtask

  task automatic finish_now();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit lat = 1'b0, input bit use_exp = 1'b0,
                      input logic [W-1:0] xd = '0, input logic xs = 1'b0);
    int waited;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    #1;
    while (!in_ready) begin
      if (waited == 300) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout: got 0 for %0d cycles, required 1", waited);
        finish_now();
      end
      @(negedge clk);
      #1;
      waited++;
    end
    model_beat(op, a, b, lat, use_exp, xd, xs);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_op = 2'($urandom);
    in_a = $urandom;
    in_b = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    idle();
    while (expq.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding, required 0", expq.size());
      expq.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  function automatic logic [W-1:0] rand_operand();
    int s;
    case ($urandom_range(0, 3))
      0: return corners[$urandom_range(0, 7)];
      1: return $urandom;
      default: begin
        s = int'($urandom_range(0, 32'h000FFFFF)) - 32'h00080000;
        return s;
      end
    endcase
  endfunction

  // Monitor: samples mid-cycle after all bench drives have settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        holding = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL out_valid_in_reset: got %b, required 0", out_valid);
        end
      end else if (out_valid) begin
        if (holding) begin
          checks++;
          if (out_data !== hold_data || out_sat !== hold_sat) begin
            errors++;
            $display("FAIL stall_hold: got %h/%b, required %h/%b",
                     out_data, out_sat, hold_data, hold_sat);
          end
        end else begin
          first_cyc = cyc;
          hold_data = out_data;
          hold_sat  = out_sat;
        end
        if (out_ready) begin
          holding = 1'b0;
          checks++;
          if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got %h, required no beat", out_data);
          end else begin
            e = expq.pop_front();
            beats_out++;
            $display("beat %0d: data=%h sat=%b", beats_out, out_data, out_sat);
            if (out_data !== e.data || out_sat !== e.sat) begin
              errors++;
              $display("FAIL result: got %h/%b, required %h/%b", out_data, out_sat, e.data, e.sat);
            end
            if (e.lat) begin
              checks++;
              if (first_cyc - e.acc_cyc != 3) begin
                errors++;
                $display("FAIL latency: got %0d, required 3", first_cyc - e.acc_cyc);
              end
            end
          end
        end else begin
          holding = 1'b1;
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", W'(in_ready), 32'd1);
    chk("reset_out_valid", W'(out_valid), 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_out_sat", W'(out_sat), 32'd0);

    send(OP_MUL, 32'h00018000, 32'h00020000, 1'b1, 1'b1, 32'h00030000, 1'b0);
    drain();

    send(OP_ADD, 32'h7FFF0000, 32'h00020000, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1);
    send(OP_ADD, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, 1'b1);
    send(OP_MUL, 32'h00000001, 32'h00008000, 1'b0, 1'b1, 32'h00000001, 1'b0);
    send(OP_MUL, 32'hFFFFFFFF, 32'h00008000, 1'b0, 1'b1, 32'h00000000, 1'b0);
    send(OP_MUL, 32'hFFFFFFFF, 32'hFFFF8000, 1'b0, 1'b1, 32'h00000001, 1'b0);
    drain();

    repeat (3) send(OP_MAC, 32'h00010000, 32'h00010000);
    send(OP_MAC_LAST, 32'h00010000, 32'h00008000, 1'b0, 1'b1, 32'h00038000, 1'b0);
    send(OP_MAC_LAST, 32'h00010000, 32'h00010000, 1'b0, 1'b1, 32'h00010000, 1'b0);
    drain();

    // Backpressure: pipe fills with the output stalled, then everything must come out in order.
    @(negedge clk);
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(OP_MUL, W'((i + 1) * 32'h00010000), 32'h00020000 + W'(i));
        idle();
      end
      begin
        repeat (8) @(negedge clk);
        chk("bp_in_ready_low", W'(in_ready), 32'd0);
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset in the middle of an accumulation discards the partial sum.
    send(OP_MAC, 32'h00010000, 32'h00010000);
    send(OP_MAC, 32'h00010000, 32'h00010000);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    expq.delete();
    m_acc = 0;
    m_acc_sat = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(OP_MAC_LAST, 32'h00010000, 32'h00010000, 1'b0, 1'b1, 32'h00010000, 1'b0);
    drain();

    // Random traffic with random downstream stalls.
    bp_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 400; i++)
          send(2'($urandom_range(0, 3)), rand_operand(), rand_operand());
        idle();
        bp_en = 1'b0;
      end
      begin
        while (bp_en) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    finish_now();
  end

endmodule
